// File: rtl/csi2_packet_parser.sv
// CSI-2 packet parser for a merged 2-lane byte stream.
// Decodes headers, emits sync pulses, forwards pixel payload, strips CRC.
module csi2_packet_parser #(
  parameter logic [5:0] PIX_DT  = 6'h2B,
  parameter logic [3:0] VC_MASK = 4'b1111
) (
  input  logic        byte_clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [15:0] in_data,
  output logic        frame_start,
  output logic        frame_end,
  output logic        line_start,
  output logic        line_end,
  output logic [15:0] frame_num,
  output logic [5:0]  pkt_dt,
  output logic [1:0]  pkt_vc,
  output logic [15:0] pkt_wc,
  output logic [7:0]  pkt_ecc,
  output logic        pix_valid,
  output logic [15:0] pix_data,
  output logic [1:0]  pix_be,
  output logic        pix_last,
  output logic        err_trunc,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR1,
    S_PAY,
    S_CRC2,
    S_CRC1,
    S_EOT
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] w0_q, w0_d;
  logic [15:0] rem_q, rem_d;
  logic        fwd_q, fwd_d;

  logic        fs_q, fs_d;
  logic        fe_q, fe_d;
  logic        ls_q, ls_d;
  logic        le_q, le_d;
  logic [15:0] fnum_q, fnum_d;
  logic [5:0]  dt_q, dt_d;
  logic [1:0]  vc_q, vc_d;
  logic [15:0] wc_q, wc_d;
  logic [7:0]  ecc_q, ecc_d;
  logic        pv_q, pv_d;
  logic [15:0] pd_q, pd_d;
  logic [1:0]  pbe_q, pbe_d;
  logic        pl_q, pl_d;
  logic        tr_q, tr_d;

  logic [5:0]  hdr_dt;
  logic [1:0]  hdr_vc;
  logic [15:0] hdr_wc;
  logic        hdr_acc;

  assign hdr_dt  = w0_q[5:0];
  assign hdr_vc  = w0_q[7:6];
  assign hdr_wc  = {in_data[7:0], w0_q[15:8]};
  assign hdr_acc = VC_MASK[hdr_vc];

  // State register and all registered outputs.
  always_ff @(posedge byte_clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      w0_q    <= '0;
      rem_q   <= '0;
      fwd_q   <= 1'b0;
      fs_q    <= 1'b0;
      fe_q    <= 1'b0;
      ls_q    <= 1'b0;
      le_q    <= 1'b0;
      fnum_q  <= '0;
      dt_q    <= '0;
      vc_q    <= '0;
      wc_q    <= '0;
      ecc_q   <= '0;
      pv_q    <= 1'b0;
      pd_q    <= '0;
      pbe_q   <= '0;
      pl_q    <= 1'b0;
      tr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      w0_q    <= w0_d;
      rem_q   <= rem_d;
      fwd_q   <= fwd_d;
      fs_q    <= fs_d;
      fe_q    <= fe_d;
      ls_q    <= ls_d;
      le_q    <= le_d;
      fnum_q  <= fnum_d;
      dt_q    <= dt_d;
      vc_q    <= vc_d;
      wc_q    <= wc_d;
      ecc_q   <= ecc_d;
      pv_q    <= pv_d;
      pd_q    <= pd_d;
      pbe_q   <= pbe_d;
      pl_q    <= pl_d;
      tr_q    <= tr_d;
    end
  end

  // Next-state decode: header capture, payload counting, CRC strip.
  always_comb begin
    state_d = state_q;
    w0_d    = w0_q;
    rem_d   = rem_q;
    fwd_d   = fwd_q;
    fs_d    = 1'b0;
    fe_d    = 1'b0;
    ls_d    = 1'b0;
    le_d    = 1'b0;
    fnum_d  = fnum_q;
    dt_d    = dt_q;
    vc_d    = vc_q;
    wc_d    = wc_q;
    ecc_d   = ecc_q;
    pv_d    = 1'b0;
    pd_d    = '0;
    pbe_d   = 2'b00;
    pl_d    = 1'b0;
    tr_d    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          w0_d    = in_data;
          state_d = S_HDR1;
        end
      end

      S_HDR1: begin
        if (in_valid) begin
          dt_d  = hdr_dt;
          vc_d  = hdr_vc;
          wc_d  = hdr_wc;
          ecc_d = in_data[15:8];
          if (hdr_dt <= 6'h0F) begin
            fs_d = hdr_acc && (hdr_dt == 6'h00);
            fe_d = hdr_acc && (hdr_dt == 6'h01);
            ls_d = hdr_acc && (hdr_dt == 6'h02);
            le_d = hdr_acc && (hdr_dt == 6'h03);
            if (hdr_acc && (hdr_dt <= 6'h01)) begin
              fnum_d = hdr_wc;
            end
            state_d = S_EOT;
          end else if (hdr_wc == 16'd0) begin
            fwd_d   = 1'b0;
            state_d = S_CRC2;
          end else begin
            rem_d   = hdr_wc;
            fwd_d   = hdr_acc && (hdr_dt == PIX_DT);
            state_d = S_PAY;
          end
        end else begin
          tr_d    = 1'b1;
          state_d = S_IDLE;
        end
      end

      S_PAY: begin
        if (in_valid) begin
          pv_d = fwd_q;
          if (rem_q > 16'd2) begin
            pd_d  = fwd_q ? in_data : 16'h0000;
            pbe_d = fwd_q ? 2'b11 : 2'b00;
            rem_d = rem_q - 16'd2;
          end else if (rem_q == 16'd2) begin
            pd_d    = fwd_q ? in_data : 16'h0000;
            pbe_d   = fwd_q ? 2'b11 : 2'b00;
            pl_d    = fwd_q;
            rem_d   = '0;
            state_d = S_CRC2;
          end else begin
            // High byte of this word is CRC byte 0.
            pd_d    = fwd_q ? {8'h00, in_data[7:0]} : 16'h0000;
            pbe_d   = fwd_q ? 2'b01 : 2'b00;
            pl_d    = fwd_q;
            rem_d   = '0;
            state_d = S_CRC1;
          end
        end else begin
          tr_d    = 1'b1;
          rem_d   = '0;
          state_d = S_IDLE;
        end
      end

      S_CRC2, S_CRC1: begin
        if (in_valid) begin
          state_d = S_EOT;
        end else begin
          tr_d    = 1'b1;
          state_d = S_IDLE;
        end
      end

      S_EOT: begin
        if (!in_valid) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign frame_start = fs_q;
  assign frame_end   = fe_q;
  assign line_start  = ls_q;
  assign line_end    = le_q;
  assign frame_num   = fnum_q;
  assign pkt_dt      = dt_q;
  assign pkt_vc      = vc_q;
  assign pkt_wc      = wc_q;
  assign pkt_ecc     = ecc_q;
  assign pix_valid   = pv_q;
  assign pix_data    = pd_q;
  assign pix_be      = pbe_q;
  assign pix_last    = pl_q;
  assign err_trunc   = tr_q;
  assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_csi2_packet_parser.sv
// Bench for csi2_packet_parser: directed bursts plus random bursts
// checked against a byte-level packet model.
module tb_csi2_packet_parser;

  localparam logic [3:0] VCM = 4'b0001;
  localparam logic [5:0] PDT = 6'h2B;

  logic        byte_clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = 16'h0000;
  logic        frame_start, frame_end, line_start, line_end;
  logic [15:0] frame_num;
  logic [5:0]  pkt_dt;
  logic [1:0]  pkt_vc;
  logic [15:0] pkt_wc;
  logic [7:0]  pkt_ecc;
  logic        pix_valid;
  logic [15:0] pix_data;
  logic [1:0]  pix_be;
  logic        pix_last;
  logic        err_trunc;
  logic        busy;

  csi2_packet_parser #(
    .PIX_DT (PDT),
    .VC_MASK(VCM)
  ) dut (
    .byte_clk   (byte_clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .frame_start(frame_start),
    .frame_end  (frame_end),
    .line_start (line_start),
    .line_end   (line_end),
    .frame_num  (frame_num),
    .pkt_dt     (pkt_dt),
    .pkt_vc     (pkt_vc),
    .pkt_wc     (pkt_wc),
    .pkt_ecc    (pkt_ecc),
    .pix_valid  (pix_valid),
    .pix_data   (pix_data),
    .pix_be     (pix_be),
    .pix_last   (pix_last),
    .err_trunc  (err_trunc),
    .busy       (busy)
  );

  always #5 byte_clk = ~byte_clk;

  int checks = 0;
  int failures = 0;
  int pc = 0;

  always @(posedge byte_clk) pc <= pc + 1;

  // Observed events, tagged with the edge count they follow.
  int          ot[$];
  logic [15:0] od[$];
  logic [1:0]  ob[$];
  logic        ol[$];
  int          pt[$];
  int          pcd[$];

  // Expected events from the model.
  int          et[$];
  logic [15:0] ed[$];
  logic [1:0]  eb[$];
  logic        el[$];
  int          ept[$];
  int          epc[$];

  logic [15:0] bw[$];

  logic [5:0]  m_dt;
  logic [1:0]  m_vc;
  logic [15:0] m_wc;
  logic [7:0]  m_ecc;
  logic [15:0] m_fnum;

  always @(negedge byte_clk) begin
    if (pix_valid || pix_last) begin
      ot.push_back(pc);
      od.push_back(pix_data);
      ob.push_back(pix_be);
      ol.push_back(pix_last);
    end
    if (frame_start) begin pt.push_back(pc); pcd.push_back(0); end
    if (frame_end)   begin pt.push_back(pc); pcd.push_back(1); end
    if (line_start)  begin pt.push_back(pc); pcd.push_back(2); end
    if (line_end)    begin pt.push_back(pc); pcd.push_back(3); end
    if (err_trunc)   begin pt.push_back(pc); pcd.push_back(4); end
  end

  task automatic chk(input string t, input logic [31:0] o,
                     input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", t, o, e);
    end
  endtask

  // Byte-level model: what one burst (in bw) must produce.
  task automatic model(input int s);
    int n;
    int dt;
    int vc;
    int wc;
    int pw;
    int got;
    bit acc;
    n = bw.size();
    et.delete(); ed.delete(); eb.delete(); el.delete();
    ept.delete(); epc.delete();
    if (n == 0) return;
    if (n == 1) begin
      ept.push_back(s + 1);
      epc.push_back(4);
      return;
    end
    dt = int'(bw[0][5:0]);
    vc = int'(bw[0][7:6]);
    wc = int'({bw[1][7:0], bw[0][15:8]});
    acc = VCM[vc];
    m_dt = 6'(dt);
    m_vc = 2'(vc);
    m_wc = 16'(wc);
    m_ecc = bw[1][15:8];
    if (dt <= 15) begin
      if (acc && dt <= 3) begin
        ept.push_back(s + 1);
        epc.push_back(dt);
        if (dt <= 1) m_fnum = 16'(wc);
      end
    end else begin
      pw = (wc + 1) / 2;
      got = (n - 2 < pw) ? n - 2 : pw;
      if (dt == int'(PDT) && acc) begin
        for (int j = 0; j < got; j++) begin
          et.push_back(s + 2 + j);
          ed.push_back(bw[2 + j]);
          eb.push_back((2 * j + 1 == wc) ? 2'b01 : 2'b11);
          el.push_back(j == pw - 1);
        end
      end
      if (n < 2 + pw + 1) begin
        ept.push_back(s + n);
        epc.push_back(4);
      end
    end
  endtask

  task automatic build(input logic [5:0] dt, input logic [1:0] vc,
                       input logic [15:0] wc, input bit incr,
                       input int extra, input int keep);
    logic [7:0] b[$];
    b.push_back({vc, dt});
    b.push_back(wc[7:0]);
    b.push_back(wc[15:8]);
    b.push_back(8'($urandom));
    if (dt > 6'h0F) begin
      for (int i = 0; i < int'(wc); i++)
        b.push_back(incr ? 8'(i + 1) : 8'($urandom));
      b.push_back(8'($urandom));
      b.push_back(8'($urandom));
    end
    if (b.size() % 2 != 0) b.push_back(8'($urandom));
    bw.delete();
    for (int i = 0; i < b.size(); i += 2)
      bw.push_back({b[i + 1], b[i]});
    repeat (extra) bw.push_back(16'($urandom));
    if (keep >= 0)
      while (bw.size() > keep) void'(bw.pop_back());
  endtask

  task automatic compare(input string t);
    int k;
    logic [15:0] mk;
    chk({t, ":npix"}, ot.size(), et.size());
    k = (ot.size() < et.size()) ? ot.size() : et.size();
    for (int i = 0; i < k; i++) begin
      mk = (eb[i] == 2'b01) ? 16'h00FF : 16'hFFFF;
      chk({t, ":pix_cyc"}, ot[i], et[i]);
      chk({t, ":pix_data"}, od[i] & mk, ed[i] & mk);
      chk({t, ":pix_be"}, ob[i], eb[i]);
      chk({t, ":pix_last"}, ol[i], el[i]);
    end
    chk({t, ":npulse"}, pt.size(), ept.size());
    k = (pt.size() < ept.size()) ? pt.size() : ept.size();
    for (int i = 0; i < k; i++) begin
      chk({t, ":pulse_cyc"}, pt[i], ept[i]);
      chk({t, ":pulse_kind"}, pcd[i], epc[i]);
    end
    chk({t, ":pkt_dt"}, pkt_dt, m_dt);
    chk({t, ":pkt_vc"}, pkt_vc, m_vc);
    chk({t, ":pkt_wc"}, pkt_wc, m_wc);
    chk({t, ":pkt_ecc"}, pkt_ecc, m_ecc);
    chk({t, ":frame_num"}, frame_num, m_fnum);
    chk({t, ":busy"}, busy, 1'b0);
  endtask

  task automatic clear_obs();
    ot.delete(); od.delete(); ob.delete(); ol.delete();
    pt.delete(); pcd.delete();
  endtask

  task automatic send(input string t);
    int s;
    @(posedge byte_clk);
    #1;
    clear_obs();
    s = pc + 1;
    model(s);
    foreach (bw[i]) begin
      in_valid = 1'b1;
      in_data = bw[i];
      @(posedge byte_clk);
      #1;
    end
    in_valid = 1'b0;
    in_data = 16'($urandom);
    repeat (4) @(posedge byte_clk);
    #1;
    compare(t);
  endtask

  initial begin
    logic [5:0] rdt;
    int sel;
    int keep;
    m_dt = '0; m_vc = '0; m_wc = '0; m_ecc = '0; m_fnum = '0;
    repeat (3) @(posedge byte_clk);
    #1;
    chk("rst:busy", busy, 1'b0);
    chk("rst:pix_valid", pix_valid, 1'b0);
    chk("rst:frame_num", frame_num, 16'h0);
    chk("rst:pkt_wc", pkt_wc, 16'h0);
    reset = 1'b1;
    repeat (2) @(posedge byte_clk);

    build(6'h00, 2'd0, 16'd5, 1'b0, 0, -1);
    send("fs");
    build(PDT, 2'd0, 16'd6, 1'b1, 0, -1);
    send("raw_even");
    build(PDT, 2'd0, 16'd5, 1'b1, 0, -1);
    send("raw_odd");
    build(6'h00, 2'd0, 16'd7, 1'b0, 1, -1);
    send("fs_after_odd");
    build(6'h12, 2'd0, 16'd4, 1'b0, 0, -1);
    send("embedded");
    build(PDT, 2'd1, 16'd4, 1'b0, 0, -1);
    send("masked_vc");
    build(6'h00, 2'd2, 16'd9, 1'b0, 0, -1);
    send("masked_fs");
    build(PDT, 2'd0, 16'd0, 1'b0, 0, -1);
    send("wc_zero");
    build(PDT, 2'd0, 16'd100, 1'b0, 0, 12);
    send("trunc_pay");
    build(6'h02, 2'd0, 16'd0, 1'b0, 0, -1);
    send("ls_after_trunc");
    build(6'h01, 2'd0, 16'd3, 1'b0, 0, 1);
    send("trunc_hdr");
    build(PDT, 2'd0, 16'd4, 1'b0, 0, 4);
    send("trunc_crc");

    // Reset mid-payload.
    build(PDT, 2'd0, 16'd100, 1'b0, 0, -1);
    @(posedge byte_clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data = bw[i];
      @(posedge byte_clk);
      #1;
    end
    chk("mid:pix_valid", pix_valid, 1'b1);
    chk("mid:busy", busy, 1'b1);
    reset = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("rst2:pix_valid", pix_valid, 1'b0);
    chk("rst2:pix_data", pix_data, 16'h0);
    chk("rst2:busy", busy, 1'b0);
    chk("rst2:pkt_dt", pkt_dt, 6'h0);
    chk("rst2:pkt_wc", pkt_wc, 16'h0);
    chk("rst2:frame_num", frame_num, 16'h0);
    m_dt = '0; m_vc = '0; m_wc = '0; m_ecc = '0; m_fnum = '0;
    repeat (2) @(posedge byte_clk);
    #1;
    reset = 1'b1;
    build(6'h03, 2'd0, 16'd2, 1'b0, 0, -1);
    send("le_after_rst");

    for (int r = 0; r < 40; r++) begin
      sel = int'($urandom_range(0, 7));
      case (sel)
        0, 1, 2, 3: rdt = 6'(sel);
        4: rdt = 6'(4 + $urandom_range(0, 11));
        5: rdt = 6'h12;
        6: rdt = 6'(16 + $urandom_range(0, 47));
        default: rdt = PDT;
      endcase
      if ($urandom_range(0, 2) == 0) rdt = PDT;
      keep = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 8)) : -1;
      build(rdt, 2'($urandom), 16'($urandom_range(0, 24)), 1'b0,
            int'($urandom_range(0, 2)), keep);
      send("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
